// File: rtl/gpio_pkg.sv
// rtl/gpio_pkg.sv - register map constants shared by the GPIO pin controller
package gpio_pkg;

  localparam int GPIO_ADDR_W = 3;

  typedef logic [GPIO_ADDR_W-1:0] gpio_addr_t;

  localparam gpio_addr_t GPIO_DIR      = 3'd0;
  localparam gpio_addr_t GPIO_OUT      = 3'd1;
  localparam gpio_addr_t GPIO_IN       = 3'd2;
  localparam gpio_addr_t GPIO_RISE_EN  = 3'd3;
  localparam gpio_addr_t GPIO_FALL_EN  = 3'd4;
  localparam gpio_addr_t GPIO_STATUS   = 3'd5;
  localparam gpio_addr_t GPIO_DB_LIMIT = 3'd6;

endpackage

// File: rtl/gpio_pin_filter.sv
// rtl/gpio_pin_filter.sv - one pin: input synchroniser, debounce counter, edge pulses
module gpio_pin_filter
  import gpio_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_WIDTH    = 8
) (
  input  logic                pclk,
  input  logic                p_reset,
  input  logic                pin_raw,
  input  logic [DB_WIDTH-1:0] db_limit,
  output logic                stable,
  output logic                rise,
  output logic                fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_WIDTH-1:0]    cnt_q;
  logic                   stable_q;
  logic                   sync;
  logic                   accept;

  assign sync   = sync_q[SYNC_STAGES-1];
  // >= rather than == so that lowering the limit under a running count
  // accepts on the next cycle instead of waiting for a wrap
  assign accept = (sync != stable_q) && (cnt_q >= db_limit);
  assign rise   = accept & sync;
  assign fall   = accept & ~sync;
  assign stable = stable_q;

  // Synchronise the pad, then accept a new level once it has differed from
  // the stable value for db_limit+1 consecutive cycles
  always_ff @(posedge pclk) begin
    if (p_reset) begin
      sync_q   <= '0;
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_raw};
      if (sync == stable_q) begin
        cnt_q <= '0;
      end else if (accept) begin
        stable_q <= sync;
        cnt_q    <= '0;
      end else begin
        cnt_q <= cnt_q + DB_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/gpio_pin_ctrl.sv
// rtl/gpio_pin_ctrl.sv - parametrised GPIO controller with debounce and edge interrupts
module gpio_pin_ctrl
  import gpio_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DB_WIDTH    = 8,
  parameter int DB_RESET    = 4
) (
  input  logic                   pclk,
  input  logic                   p_reset,
  input  logic                   reg_wr,
  input  logic [GPIO_ADDR_W-1:0] reg_addr,
  input  logic [DATA_WIDTH-1:0]  reg_wdata,
  output logic [DATA_WIDTH-1:0]  reg_rdata,
  input  logic [DATA_WIDTH-1:0]  gpio_pin_in,
  output logic [DATA_WIDTH-1:0]  gpio_pin_out,
  output logic [DATA_WIDTH-1:0]  n_gpio_pin_oe,
  output logic                   irq
);

  logic [DATA_WIDTH-1:0] dir_q;
  logic [DATA_WIDTH-1:0] out_q;
  logic [DATA_WIDTH-1:0] rise_en_q;
  logic [DATA_WIDTH-1:0] fall_en_q;
  logic [DATA_WIDTH-1:0] status_q;
  logic [DB_WIDTH-1:0]   db_limit_q;
  logic                  irq_q;

  logic [DATA_WIDTH-1:0] in_stable;
  logic [DATA_WIDTH-1:0] rise_vec;
  logic [DATA_WIDTH-1:0] fall_vec;
  logic [DATA_WIDTH-1:0] status_set;
  logic [DATA_WIDTH-1:0] status_clr;

  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_pin
    gpio_pin_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_WIDTH    (DB_WIDTH)
    ) u_filter (
      .pclk     (pclk),
      .p_reset  (p_reset),
      .pin_raw  (gpio_pin_in[i]),
      .db_limit (db_limit_q),
      .stable   (in_stable[i]),
      .rise     (rise_vec[i]),
      .fall     (fall_vec[i])
    );
  end

  assign status_set = (rise_vec & rise_en_q) | (fall_vec & fall_en_q);
  assign status_clr = (reg_wr && (reg_addr == GPIO_STATUS)) ? reg_wdata : '0;

  assign n_gpio_pin_oe = ~dir_q;
  assign gpio_pin_out  = out_q;
  assign irq           = irq_q;

  // Register writes, sticky status (a new edge beats a same-cycle clear) and irq
  always_ff @(posedge pclk) begin
    if (p_reset) begin
      dir_q      <= '0;
      out_q      <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      db_limit_q <= DB_WIDTH'(DB_RESET);
      irq_q      <= 1'b0;
    end else begin
      if (reg_wr) begin
        case (reg_addr)
          GPIO_DIR:      dir_q      <= reg_wdata;
          GPIO_OUT:      out_q      <= reg_wdata;
          GPIO_RISE_EN:  rise_en_q  <= reg_wdata;
          GPIO_FALL_EN:  fall_en_q  <= reg_wdata;
          GPIO_DB_LIMIT: db_limit_q <= DB_WIDTH'(reg_wdata);
          default: ;
        endcase
      end
      status_q <= (status_q & ~status_clr) | status_set;
      irq_q    <= |status_q;
    end
  end

  // Read mux; IN returns the debounced levels, unused addresses read zero
  always_comb begin
    reg_rdata = '0;
    case (reg_addr)
      GPIO_DIR:      reg_rdata = dir_q;
      GPIO_OUT:      reg_rdata = out_q;
      GPIO_IN:       reg_rdata = in_stable;
      GPIO_RISE_EN:  reg_rdata = rise_en_q;
      GPIO_FALL_EN:  reg_rdata = fall_en_q;
      GPIO_STATUS:   reg_rdata = status_q;
      GPIO_DB_LIMIT: reg_rdata = DATA_WIDTH'(db_limit_q);
      default:       reg_rdata = '0;
    endcase
  end

endmodule
